orientation_histogram: RTL and testbench

Downstream consumer of the gradient stage: given a keypoint location, it reads an 8×8 window from the x- and y-gradient BRAMs that `gradient_image` fills. For each pixel it computes an L1 magnitude and an octant orientation bin, then accumulates an 8-bin magnitude-weighted histogram. The histogram is streamed out one bin per cycle and forms the raw material for SIFT keypoint orientation and descriptors.

---
 rtl/sift_pkg.sv | 16 +
 rtl/grad_binner.sv | 62 ++++++
 rtl/orientation_histogram.sv | 162 ++++++++++++++++
 tb/tb_orientation_histogram.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Types and constants shared by the SIFT orientation stages.
package sift_pkg;

  localparam int unsigned NUM_BINS = 8;

  typedef logic [2:0] bin_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    OUTPUT,
    DONE
  } hist_state_t;

endpackage

// File: rtl/grad_binner.sv
// Per-pixel L1 gradient magnitude and octant bin, one registered stage.
module grad_binner
  import sift_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BIT_DEPTH:0] i_dx,
  input  logic [BIT_DEPTH:0] i_dy,
  output logic [2:0]         o_bin,
  output logic [BIT_DEPTH+1:0] o_mag
);

  localparam logic [BIT_DEPTH:0] One = {{BIT_DEPTH{1'b0}}, 1'b1};

  logic               w_sx;
  logic               w_sy;
  logic [BIT_DEPTH:0] w_ax;
  logic [BIT_DEPTH:0] w_ay;
  logic               w_x_gt;
  logic               w_y_ge;
  logic [BIT_DEPTH+1:0] w_mag;
  bin_t               w_bin;
  bin_t               r_bin;
  logic [BIT_DEPTH+1:0] r_mag;

  assign w_sx = i_dx[BIT_DEPTH];
  assign w_sy = i_dy[BIT_DEPTH];

  // The most negative value negates to itself, which read unsigned is its true magnitude.
  assign w_ax = w_sx ? (~i_dx + One) : i_dx;
  assign w_ay = w_sy ? (~i_dy + One) : i_dy;

  assign w_x_gt = w_ax > w_ay;
  assign w_y_ge = w_ay >= w_ax;
  assign w_mag  = {1'b0, w_ax} + {1'b0, w_ay};

  always_comb begin
    w_bin = 3'd0;
    unique case ({w_sx, w_sy})
      2'b00:   w_bin = w_x_gt ? 3'd0 : 3'd1;
      2'b10:   w_bin = w_y_ge ? 3'd2 : 3'd3;
      2'b11:   w_bin = w_x_gt ? 3'd4 : 3'd5;
      default: w_bin = w_y_ge ? 3'd6 : 3'd7;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin <= '0;
      r_mag <= '0;
    end else begin
      r_bin <= w_bin;
      r_mag <= w_mag;
    end
  end

  assign o_bin = r_bin;
  assign o_mag = r_mag;

endmodule

// File: rtl/orientation_histogram.sv
// Reads a clamped window of gradients around a keypoint and streams out an
// 8-bin magnitude-weighted orientation histogram.
module orientation_histogram
  import sift_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned HEIGHT    = 64,
  parameter int unsigned WINDOW    = 8
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic                                      start_in,
  input  logic [$clog2(WIDTH)-1:0]                  key_x,
  input  logic [$clog2(HEIGHT)-1:0]                 key_y,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]           ext_read_addr,
  output logic                                      ext_read_addr_valid,
  input  logic [BIT_DEPTH:0]                        x_pixel_in,
  input  logic [BIT_DEPTH:0]                        y_pixel_in,
  output logic [2:0]                                bin_index,
  output logic [BIT_DEPTH+1+$clog2(WINDOW*WINDOW):0] bin_value,
  output logic                                      bin_valid,
  output logic                                      busy,
  output logic                                      hist_done
);

  localparam int unsigned XW       = $clog2(WIDTH);
  localparam int unsigned YW       = $clog2(HEIGHT);
  localparam int unsigned AW       = $clog2(WIDTH * HEIGHT);
  localparam int unsigned WW       = $clog2(WINDOW);
  localparam int unsigned MW       = BIT_DEPTH + 2;
  localparam int unsigned AccW     = BIT_DEPTH + 2 + $clog2(WINDOW * WINDOW);
  localparam int unsigned Half     = WINDOW / 2;
  localparam logic [2:0]  DrainEnd = 3'd2;
  localparam logic [2:0]  OutEnd   = 3'(NUM_BINS - 1);
  localparam logic [WW-1:0] WinEnd = WW'(WINDOW - 1);

  hist_state_t r_state;
  hist_state_t w_state_next;

  logic [XW-1:0]   r_key_x;
  logic [YW-1:0]   r_key_y;
  logic [WW-1:0]   r_wx;
  logic [WW-1:0]   r_wy;
  logic [2:0]      r_cnt;
  logic [2:0]      r_vld;
  logic [AccW-1:0] r_acc [NUM_BINS];

  logic            w_start;
  logic            w_win_last;
  logic [XW+1:0]   w_sum_x;
  logic [XW+1:0]   w_off_x;
  logic [YW+1:0]   w_sum_y;
  logic [YW+1:0]   w_off_y;
  logic [XW-1:0]   w_cx;
  logic [YW-1:0]   w_cy;
  logic [AW-1:0]   w_addr;
  bin_t            w_bin;
  logic [MW-1:0]   w_mag;

  assign w_start    = (r_state == IDLE) && start_in;
  assign w_win_last = (r_wx == WinEnd) && (r_wy == WinEnd);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start_in) w_state_next = READ;
      READ:    if (w_win_last) w_state_next = DRAIN;
      DRAIN:   if (r_cnt == DrainEnd) w_state_next = OUTPUT;
      OUTPUT:  if (r_cnt == OutEnd) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_key_x <= '0;
      r_key_y <= '0;
      r_wx    <= '0;
      r_wy    <= '0;
      r_cnt   <= '0;
      r_vld   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_key_x <= key_x;
        r_key_y <= key_y;
        r_wx    <= '0;
        r_wy    <= '0;
      end else if (r_state == READ) begin
        r_wx <= r_wx + 1'b1;
        if (r_wx == WinEnd) r_wy <= r_wy + 1'b1;
      end
      if (r_state != w_state_next) begin
        r_cnt <= '0;
      end else if ((r_state == DRAIN) || (r_state == OUTPUT)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Two BRAM stages plus the binner stage; reset drops anything in flight.
      r_vld <= {r_vld[1:0], r_state == READ};
    end
  end

  // Window origin is key - WINDOW/2; each axis is clamped to the image for border replication.
  always_comb begin
    w_sum_x = {2'b00, r_key_x} + (XW + 2)'(r_wx);
    w_off_x = w_sum_x - (XW + 2)'(Half);
    w_cx    = '0;
    if (w_sum_x < (XW + 2)'(Half)) begin
      w_cx = '0;
    end else if (w_off_x > (XW + 2)'(WIDTH - 1)) begin
      w_cx = XW'(WIDTH - 1);
    end else begin
      w_cx = w_off_x[XW-1:0];
    end

    w_sum_y = {2'b00, r_key_y} + (YW + 2)'(r_wy);
    w_off_y = w_sum_y - (YW + 2)'(Half);
    w_cy    = '0;
    if (w_sum_y < (YW + 2)'(Half)) begin
      w_cy = '0;
    end else if (w_off_y > (YW + 2)'(HEIGHT - 1)) begin
      w_cy = YW'(HEIGHT - 1);
    end else begin
      w_cy = w_off_y[YW-1:0];
    end

    w_addr = AW'(w_cy) * AW'(WIDTH) + AW'(w_cx);
  end

  grad_binner #(
    .BIT_DEPTH (BIT_DEPTH)
  ) u_grad_binner (
    .i_clk (clk_in),
    .i_rst (rst_in),
    .i_dx  (x_pixel_in),
    .i_dy  (y_pixel_in),
    .o_bin (w_bin),
    .o_mag (w_mag)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_BINS; i++) r_acc[i] <= '0;
    end else if (w_start) begin
      for (int i = 0; i < NUM_BINS; i++) r_acc[i] <= '0;
    end else if (r_vld[2]) begin
      r_acc[w_bin] <= r_acc[w_bin] + AccW'(w_mag);
    end
  end

  assign ext_read_addr_valid = (r_state == READ);
  assign ext_read_addr       = ext_read_addr_valid ? w_addr : '0;
  assign bin_valid           = (r_state == OUTPUT);
  assign bin_index           = bin_valid ? r_cnt : 3'd0;
  assign bin_value           = bin_valid ? r_acc[r_cnt] : '0;
  assign busy                = (r_state == READ) || (r_state == DRAIN) || (r_state == OUTPUT);
  assign hist_done           = (r_state == DONE);

endmodule

// File: tb/tb_orientation_histogram.sv
// Directed bench for orientation_histogram with a 2-cycle gradient BRAM model.
module tb_orientation_histogram;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  kx;
  logic [5:0]  ky;
  logic [11:0] addr;
  logic        addr_v;
  logic [8:0]  xin;
  logic [8:0]  yin;
  logic [2:0]  bidx;
  logic [15:0] bval;
  logic        bv;
  logic        busy;
  logic        done;

  logic [8:0]  gb_dx;
  logic [8:0]  gb_dy;
  logic [2:0]  gb_bin;
  logic [9:0]  gb_mag;

  logic [8:0]  mem_x [0:4095];
  logic [8:0]  mem_y [0:4095];
  logic [8:0]  bx1, by1;

  int errors = 0;
  int checks = 0;

  // Per-run capture, filled by run_hist
  logic [11:0] addr_seq[$];
  logic [2:0]  idx_seq[$];
  logic [15:0] bins_got [8];
  logic        busy_log [0:90];
  int addr_first, addr_last, bin_first, bin_last, done_off, done_cnt, val_leak;

  always #5 clk = ~clk;

  orientation_histogram #(
    .BIT_DEPTH (8),
    .WIDTH     (64),
    .HEIGHT    (64),
    .WINDOW    (8)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .start_in            (start),
    .key_x               (kx),
    .key_y               (ky),
    .ext_read_addr       (addr),
    .ext_read_addr_valid (addr_v),
    .x_pixel_in          (xin),
    .y_pixel_in          (yin),
    .bin_index           (bidx),
    .bin_value           (bval),
    .bin_valid           (bv),
    .busy                (busy),
    .hist_done           (done)
  );

  grad_binner #(
    .BIT_DEPTH (8)
  ) u_gb (
    .i_clk (clk),
    .i_rst (rst),
    .i_dx  (gb_dx),
    .i_dy  (gb_dy),
    .o_bin (gb_bin),
    .o_mag (gb_mag)
  );

  always @(posedge clk) begin
    if (addr_v) begin
      bx1 <= mem_x[addr];
      by1 <= mem_y[addr];
    end
    xin <= bx1;
    yin <= by1;
  end

  task automatic fill(input int dx, input int dy);
    for (int i = 0; i < 4096; i++) begin
      mem_x[i] = dx[8:0];
      mem_y[i] = dy[8:0];
    end
  endtask

  task automatic run_hist(input logic [5:0] x, input logic [5:0] y, input bit repulse);
    addr_seq.delete();
    idx_seq.delete();
    for (int b = 0; b < 8; b++) bins_got[b] = 16'hxxxx;
    addr_first = -1; addr_last = -1; bin_first = -1; bin_last = -1;
    done_off = -1; done_cnt = 0; val_leak = 0;
    @(negedge clk);
    kx = x; ky = y; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (repulse && n == 10) begin start = 1'b1; kx = 6'd0; ky = 6'd0; end
      if (repulse && n == 11) start = 1'b0;
      if (addr_v) begin
        addr_seq.push_back(addr);
        if (addr_first < 0) addr_first = n;
        addr_last = n;
      end
      if (bv) begin
        bins_got[bidx] = bval;
        idx_seq.push_back(bidx);
        if (bin_first < 0) bin_first = n;
        bin_last = n;
      end else if (bval !== 16'd0) begin
        val_leak++;
      end
      if (done) begin
        done_cnt++;
        if (done_off < 0) done_off = n;
      end
      busy_log[n] = busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kx = '0; ky = '0;
    gb_dx = '0; gb_dy = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({addr, addr_v, bidx, bval, bv, busy, done} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {addr, addr_v, bidx, bval, bv, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({addr_v, busy, bv, done} !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b required 0000", {addr_v, busy, bv, done});
    end
  endtask

  task automatic test_uniform_pos();
    int bad;
    logic [15:0] exp;
    logic [11:0] ea;
    fill(10, 0);
    run_hist(6'd32, 6'd32, 1'b0);
    checks++;
    if (addr_seq.size() != 64) begin
      errors++;
      $display("FAIL pos_addr_count: got %0d required 64", addr_seq.size());
    end
    checks++;
    if (addr_first != 1 || addr_last != 64) begin
      errors++;
      $display("FAIL pos_addr_window: got %0d..%0d required 1..64", addr_first, addr_last);
    end
    bad = 0;
    for (int i = 0; i < 64 && i < addr_seq.size(); i++) begin
      ea = 12'((28 + i / 8) * 64 + 28 + i % 8);
      if (addr_seq[i] !== ea) begin
        if (bad == 0) $display("FAIL pos_raster[%0d]: got %0d required %0d", i, addr_seq[i], ea);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (addr_seq.size() < 64 || addr_seq[0] !== 12'd1820 || addr_seq[63] !== 12'd2275) begin
      errors++;
      $display("FAIL pos_addr_ends: required 1820 and 2275");
    end
    for (int b = 0; b < 8; b++) begin
      exp = (b == 0) ? 16'd640 : 16'd0;
      checks++;
      if (bins_got[b] !== exp) begin
        errors++;
        $display("FAIL pos_bin%0d: got %0d required %0d", b, bins_got[b], exp);
      end
    end
    checks++;
    if (bin_first != 68 || bin_last != 75) begin
      errors++;
      $display("FAIL pos_bin_valid_window: got %0d..%0d required 68..75", bin_first, bin_last);
    end
    bad = 0;
    for (int i = 0; i < idx_seq.size(); i++) if (idx_seq[i] !== 3'(i)) bad++;
    checks++;
    if (idx_seq.size() != 8 || bad != 0) begin
      errors++;
      $display("FAIL pos_bin_order: got %0d bins, %0d out of order, required 8 and 0",
               idx_seq.size(), bad);
    end
    checks++;
    if (done_off != 76 || done_cnt != 1) begin
      errors++;
      $display("FAIL pos_done: got cycle %0d count %0d required 76 and 1", done_off, done_cnt);
    end
    checks++;
    if ({busy_log[1], busy_log[75], busy_log[76], busy_log[77]} !== 4'b1100) begin
      errors++;
      $display("FAIL pos_busy: got %b required 1100",
               {busy_log[1], busy_log[75], busy_log[76], busy_log[77]});
    end
    checks++;
    if (val_leak != 0) begin
      errors++;
      $display("FAIL pos_value_leak: got %0d required 0", val_leak);
    end
  endtask

  task automatic test_uniform_neg();
    logic [15:0] exp;
    fill(-256, -256);
    run_hist(6'd32, 6'd32, 1'b0);
    for (int b = 0; b < 8; b++) begin
      exp = (b == 5) ? 16'd32768 : 16'd0;
      checks++;
      if (bins_got[b] !== exp) begin
        errors++;
        $display("FAIL neg_bin%0d: got %0d required %0d", b, bins_got[b], exp);
      end
    end
    checks++;
    if (done_off != 76) begin
      errors++;
      $display("FAIL neg_done: got %0d required 76", done_off);
    end
  endtask

  task automatic test_corner_clamp();
    logic [15:0] exp;
    int zeros;
    fill(0, 0);
    mem_x[0] = 9'd5;
    mem_y[0] = 9'd5;
    run_hist(6'd0, 6'd0, 1'b0);
    checks++;
    if (addr_seq.size() == 0 || addr_seq[0] !== 12'd0) begin
      errors++;
      $display("FAIL corner_first_addr: required 0");
    end
    zeros = 0;
    foreach (addr_seq[i]) if (addr_seq[i] == 12'd0) zeros++;
    checks++;
    if (zeros != 25) begin
      errors++;
      $display("FAIL corner_pixel0_reads: got %0d required 25", zeros);
    end
    for (int b = 0; b < 8; b++) begin
      exp = (b == 1) ? 16'd250 : 16'd0;
      checks++;
      if (bins_got[b] !== exp) begin
        errors++;
        $display("FAIL corner_bin%0d: got %0d required %0d", b, bins_got[b], exp);
      end
    end
  endtask

  task automatic test_binner_octants();
    int vdx  [14] = '{10, 3, 0, 0, -3, -5, -1, -5, -3, -256, 4, 4, 0, 255};
    int vdy  [14] = '{0, 3, 0, 7, 3, 2, 0, -2, -3, -256, -4, -1, -3, -256};
    int vbin [14] = '{0, 1, 1, 1, 2, 3, 3, 4, 5, 5, 6, 7, 6, 6};
    int vmag [14] = '{10, 6, 0, 7, 6, 7, 1, 7, 6, 512, 8, 5, 3, 511};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      gb_dx = vdx[i][8:0];
      gb_dy = vdy[i][8:0];
      @(negedge clk);
      checks++;
      if (gb_bin !== vbin[i][2:0] || gb_mag !== vmag[i][9:0]) begin
        errors++;
        $display("FAIL binner(%0d,%0d): got bin %0d mag %0d required bin %0d mag %0d",
                 vdx[i], vdy[i], gb_bin, gb_mag, vbin[i], vmag[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] exp;
    fill(10, 0);
    run_hist(6'd32, 6'd32, 1'b1);
    for (int b = 0; b < 8; b++) begin
      exp = (b == 0) ? 16'd640 : 16'd0;
      checks++;
      if (bins_got[b] !== exp) begin
        errors++;
        $display("FAIL repulse_bin%0d: got %0d required %0d", b, bins_got[b], exp);
      end
    end
    checks++;
    if (done_off != 76 || done_cnt != 1) begin
      errors++;
      $display("FAIL repulse_done: got cycle %0d count %0d required 76 and 1", done_off, done_cnt);
    end
    checks++;
    if (addr_seq.size() != 64 || addr_seq[0] !== 12'd1820 || addr_seq[63] !== 12'd2275) begin
      errors++;
      $display("FAIL repulse_addrs: got %0d addresses, required 64 from 1820 to 2275",
               addr_seq.size());
    end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] exp;
    fill(10, 0);
    @(negedge clk);
    kx = 6'd32; ky = 6'd32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({addr, addr_v, bidx, bval, bv, busy, done} !== 33'd0) begin
      errors++;
      $display("FAIL midread_reset_outputs: got %h required 0",
               {addr, addr_v, bidx, bval, bv, busy, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fill(0, -20);
    run_hist(6'd32, 6'd32, 1'b0);
    for (int b = 0; b < 8; b++) begin
      exp = (b == 6) ? 16'd1280 : 16'd0;
      checks++;
      if (bins_got[b] !== exp) begin
        errors++;
        $display("FAIL after_reset_bin%0d: got %0d required %0d", b, bins_got[b], exp);
      end
    end
    checks++;
    if (done_off != 76) begin
      errors++;
      $display("FAIL after_reset_done: got %0d required 76", done_off);
    end
  endtask

  initial begin
    test_reset();
    test_uniform_pos();
    test_uniform_neg();
    test_corner_clamp();
    test_binner_octants();
    test_start_ignored();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
